adder_seq_ctrl: RTL and testbench

//   Nibble-serial wide-add sequencer. Accepts a WIDTH-bit add request (a, b,

---
 rtl/adder_seq_ctrl.sv | 147 ++++++++++++++
 tb/tb_adder_seq_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq_ctrl.sv
// Nibble-serial wide adder: one shared 4-bit adder processes a WIDTH-bit add
// over WIDTH/4 cycles, least significant nibble first, with a registered carry chain.
`timescale 1ns/1ps

module adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] full_s;

    // 4-bit ripple add with carry in/out
    assign full_s = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};
    assign sum    = full_s[3:0];
    assign c_out  = full_s[4];
endmodule

module adder_seq_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             busy
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       nib_sum_s;
    logic             nib_c_s;

    adder u_adder (
        .a     (a_q[3:0]),
        .b     (b_q[3:0]),
        .c_in  (carry_q),
        .sum   (nib_sum_s),
        .c_out (nib_c_s)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update; the carry register doubles as the
    // final carry-out once the last nibble has been added.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_c;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d     = {4'b0000, a_q[WIDTH-1:4]};
                b_d     = {4'b0000, b_q[WIDTH-1:4]};
                sum_d   = {nib_sum_s, sum_q[WIDTH-1:4]};
                carry_d = nib_c_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake/status decode from the registered state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE:  in_ready  = 1'b1;
            S_RUN:   busy      = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign out_sum = sum_q;
    assign out_c   = carry_q;
endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: a driver pushes a+b+c into a queue on
// every accepted request; an independent monitor pops and compares on output.
`timescale 1ns/1ps

module tb_adder_seq_ctrl;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_c;
    logic             busy;

    adder_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ready_mode = 0;
    int ready_hold = 0;

    logic [WIDTH:0] exp_q[$];
    int             acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: chooses out_ready, then judges the handshake that the next edge will see
    logic           prev_valid = 1'b0;
    logic           prev_stall = 1'b0;
    logic           prev_hs    = 1'b0;
    logic [WIDTH:0] held       = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_stall = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (ready_hold > 0 && out_valid) begin
                out_ready = 1'b0;
                ready_hold--;
            end else if (ready_mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else begin
                out_ready = 1'b1;
            end
            if (prev_hs) begin
                check("valid_clears_after_hs", 32'(out_valid), 32'd0);
                check("ready_after_hs", 32'(in_ready), 32'd1);
            end
            if (out_valid) begin
                check("in_ready_low_in_done", 32'(in_ready), 32'd0);
                check("busy_in_done", 32'(busy), 32'd1);
                if (prev_stall)
                    check("result_held", 32'({out_c, out_sum}), 32'(held));
                if (!prev_valid) begin
                    if (acc_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h expected no result", {out_c, out_sum});
                    end else begin
                        check("latency", 32'(cyc - acc_q[0]), 32'd4);
                    end
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL extra_result: got 0x%0h expected none queued", {out_c, out_sum});
                    end else begin
                        check("result", 32'({out_c, out_sum}), 32'(exp_q.pop_front()));
                        void'(acc_q.pop_front());
                    end
                end
            end
            prev_hs    = out_valid && out_ready;
            prev_stall = out_valid && !out_ready;
            held       = {out_c, out_sum};
            prev_valid = out_valid;
        end
    end

    // Drive a request from a negedge; returns at the negedge after acceptance
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        int waited = 0;
        in_a = a;
        in_b = b;
        in_c = c;
        in_valid = 1'b1;
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end else begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c});
            acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
        end
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_c      = 1'b0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_c", 32'(out_c), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'hFFFF, 16'h0001, 1'b0);
        drain();
        issue(16'h1234, 16'h4321, 1'b1);
        drain();

        ready_hold = 10;
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        // Extra requests while RUN/DONE must be dropped
        issue(16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_c = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            check("ready_low_while_busy", 32'(in_ready), 32'd0);
            check("busy_while_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drain();

        // Reset in the middle of RUN discards the partial result
        issue(16'hAAAA, 16'h5555, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
        check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
        check("midrun_rst_busy", 32'(busy), 32'd0);
        exp_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(16'h0F0F, 16'h00F1, 1'b0);
        drain();

        ready_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            issue(ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
